addr_reg_stack: RTL and testbench

//  Parametrised address register for the Mano datapath: load, clear, increment, decrement.

---
 rtl/mano_pkg.sv | 25 ++
 rtl/lifo_stack.sv | 86 ++++++++
 rtl/addr_reg_stack.sv | 110 +++++++++++
 tb/tb_addr_reg_stack.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mano_pkg.sv
// Shared definitions for the Mano datapath blocks.
// Pure constants and a constant function; no logic.
// No flow control.
package mano_pkg;

    // Stack operation encoding, formed as {pop, push}.
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    // Ceiling log2 for sizing counters and indices (clog2(1) = 0).
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lifo_stack.sv
// LIFO save stack with level counter, FULL/EMPTY and overflow/underflow detect.
// Level/status update on the edge after the request; rd_dat shows the current top combinationally.
// No handshake: an illegal push/pop is dropped and flagged on err for that cycle.
module lifo_stack
    import mano_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wr_dat,
    output logic [WIDTH-1:0]             rd_dat,
    output logic                         pop_vld,
    output logic                         err,
    output logic                         full,
    output logic                         empty,
    output logic [clog2(DEPTH+1)-1:0]    level
);

    localparam int LW = clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    mem_widx;
    logic             mem_we;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    // Next free slot, and the slot holding the current top (meaningless when empty).
    assign wr_idx  = level_q[AW-1:0];
    assign top_idx = wr_idx - AW'(1);
    assign rd_dat  = mem_q[top_idx];
    assign pop_vld = pop && !empty;

    // Decode the requested operation into level change, storage write and error.
    always_comb begin
        level_d  = level_q;
        mem_we   = 1'b0;
        mem_widx = wr_idx;
        err      = 1'b0;
        case ({pop, push})
            OP_PUSH: begin
                if (full) begin
                    err = 1'b1;
                end else begin
                    mem_we  = 1'b1;
                    level_d = level_q + LW'(1);
                end
            end
            OP_POP: begin
                if (empty) err = 1'b1;
                else       level_d = level_q - LW'(1);
            end
            OP_SWAP: begin
                // Top is replaced in place; depth is unchanged.
                if (empty) begin
                    err = 1'b1;
                end else begin
                    mem_we   = 1'b1;
                    mem_widx = top_idx;
                end
            end
            default: ;
        endcase
    end

    // Level counter; storage contents are deliberately left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level_q <= '0;
        else        level_q <= level_d;
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_widx] <= wr_dat;
    end

endmodule

// File: rtl/addr_reg_stack.sv
// Address register (load/clear/inc/dec, wrap or saturate) with a LIFO return-address stack.
// One cycle: a request at edge N is visible after edge N; WRAP/ERR are one-cycle pulses.
// No backpressure: illegal stack requests are dropped and reported on ERR.
module addr_reg_stack
    import mano_pkg::*;
#(
    parameter int               WIDTH     = 12,
    parameter int               DEPTH     = 4,
    parameter int               SATURATE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [WIDTH-1:0]             DATA,
    input  logic                         LD,
    input  logic                         CLR,
    input  logic                         INC,
    input  logic                         DEC,
    input  logic                         PUSH,
    input  logic                         POP,
    output logic [WIDTH-1:0]             Q,
    output logic                         WRAP,
    output logic                         ERR,
    output logic                         FULL,
    output logic                         EMPTY,
    output logic [clog2(DEPTH+1)-1:0]    LEVEL
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             err_q;
    logic             err_d;
    logic [WIDTH-1:0] top_dat;
    logic             pop_vld;
    logic             stk_err;
    logic             inc_only;
    logic             dec_only;

    // The stack always saves the pre-update Q, which gives PUSH+LD call semantics.
    lifo_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (CLK),
        .rst_n   (RST_N),
        .push    (PUSH),
        .pop     (POP),
        .wr_dat  (q_q),
        .rd_dat  (top_dat),
        .pop_vld (pop_vld),
        .err     (stk_err),
        .full    (FULL),
        .empty   (EMPTY),
        .level   (LEVEL)
    );

    assign inc_only = INC && !DEC;
    assign dec_only = DEC && !INC;

    // Q next value: CLR > LD > valid POP > INC/DEC > hold; WRAP only when INC/DEC wins.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        err_d  = stk_err;
        if (CLR) begin
            q_d = '0;
        end else if (LD) begin
            q_d = DATA;
        end else if (pop_vld) begin
            q_d = top_dat;
        end else if (POP) begin
            // Underflowing pop freezes Q; INC/DEC are ignored this cycle.
            q_d = q_q;
        end else if (inc_only) begin
            if (q_q == '1) begin
                wrap_d = 1'b1;
                q_d    = (SATURATE != 0) ? q_q : '0;
            end else begin
                q_d = q_q + WIDTH'(1);
            end
        end else if (dec_only) begin
            if (q_q == '0) begin
                wrap_d = 1'b1;
                q_d    = (SATURATE != 0) ? q_q : '1;
            end else begin
                q_d = q_q - WIDTH'(1);
            end
        end
    end

    // Address register and status pulse registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_q    <= RESET_VAL;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign Q    = q_q;
    assign WRAP = wrap_q;
    assign ERR  = err_q;

endmodule

// File: tb/tb_addr_reg_stack.sv
// Bench for addr_reg_stack: wrapping and saturating instances driven in lockstep.
// Expected outputs are queued when a request is driven and compared one edge later.
// Directed scenarios plus a random phase.
module tb_addr_reg_stack;

    logic        clk;
    logic        rst_n;
    logic [11:0] data;
    logic        ld, clr, inc, dec, push, pop;

    logic [11:0] q_w, q_s;
    logic        wrap_w, wrap_s, err_w, err_s, full_w, full_s, empty_w, empty_s;
    logic [2:0]  lvl_w, lvl_s;

    int n_chk;
    int n_err;

    typedef struct {
        int          inst;
        logic [11:0] q;
        logic        wrap;
        logic        err;
        logic        full;
        logic        empty;
        logic [2:0]  lvl;
    } exp_t;

    exp_t sb[$];

    logic [11:0] m_q   [2];
    logic [11:0] m_stk [2][4];
    int          m_lvl [2];

    addr_reg_stack #(.WIDTH(12), .DEPTH(4), .SATURATE(0), .RESET_VAL(12'h000)) u_wrap (
        .CLK(clk), .RST_N(rst_n), .DATA(data), .LD(ld), .CLR(clr), .INC(inc), .DEC(dec),
        .PUSH(push), .POP(pop), .Q(q_w), .WRAP(wrap_w), .ERR(err_w), .FULL(full_w),
        .EMPTY(empty_w), .LEVEL(lvl_w)
    );

    addr_reg_stack #(.WIDTH(12), .DEPTH(4), .SATURATE(1), .RESET_VAL(12'h000)) u_sat (
        .CLK(clk), .RST_N(rst_n), .DATA(data), .LD(ld), .CLR(clr), .INC(inc), .DEC(dec),
        .PUSH(push), .POP(pop), .Q(q_s), .WRAP(wrap_s), .ERR(err_s), .FULL(full_s),
        .EMPTY(empty_s), .LEVEL(lvl_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_q[i]   = 12'h000;
            m_lvl[i] = 0;
        end
    endtask

    // Drive one request, predict both instances, then compare after the edge.
    task automatic step(input logic s_ld, input logic s_clr, input logic s_inc, input logic s_dec,
                        input logic s_push, input logic s_pop, input logic [11:0] s_data);
        exp_t        e;
        logic [11:0] q, top;
        int          lv;
        logic        sfull, sempty, popv;
        ld = s_ld; clr = s_clr; inc = s_inc; dec = s_dec;
        push = s_push; pop = s_pop; data = s_data;
        for (int i = 0; i < 2; i++) begin
            q      = m_q[i];
            lv     = m_lvl[i];
            sfull  = (lv == 4);
            sempty = (lv == 0);
            popv   = s_pop && !sempty;
            top    = sempty ? 12'h000 : m_stk[i][lv-1];
            e.inst = i;
            e.wrap = 1'b0;
            e.err  = (s_push && !s_pop && sfull) || (s_pop && sempty);
            if (s_clr)           e.q = 12'h000;
            else if (s_ld)       e.q = s_data;
            else if (popv)       e.q = top;
            else if (s_pop)      e.q = q;
            else if (s_inc && !s_dec) begin
                if (q == 12'hFFF) begin
                    e.wrap = 1'b1;
                    e.q    = (i == 1) ? q : 12'h000;
                end else e.q = q + 12'h001;
            end else if (s_dec && !s_inc) begin
                if (q == 12'h000) begin
                    e.wrap = 1'b1;
                    e.q    = (i == 1) ? q : 12'hFFF;
                end else e.q = q - 12'h001;
            end else e.q = q;
            if (s_push && s_pop && !sempty)      m_stk[i][lv-1] = q;
            else if (s_push && !s_pop && !sfull) begin m_stk[i][lv] = q; lv++; end
            else if (s_pop && !s_push && !sempty) lv--;
            m_q[i]   = e.q;
            m_lvl[i] = lv;
            e.lvl    = 3'(lv);
            e.full   = (lv == 4);
            e.empty  = (lv == 0);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.inst == 0) begin
                chk("w_q", q_w, e.q);         chk("w_wrap", wrap_w, e.wrap);
                chk("w_err", err_w, e.err);   chk("w_lvl", lvl_w, e.lvl);
                chk("w_full", full_w, e.full); chk("w_empty", empty_w, e.empty);
            end else begin
                chk("s_q", q_s, e.q);         chk("s_wrap", wrap_s, e.wrap);
                chk("s_err", err_s, e.err);   chk("s_lvl", lvl_s, e.lvl);
                chk("s_full", full_s, e.full); chk("s_empty", empty_s, e.empty);
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 12'h000);
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        ld = 0; clr = 0; inc = 0; dec = 0; push = 0; pop = 0; data = 12'h000;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_q", q_w, 12'h000);     chk("rst_empty", empty_w, 1);
        chk("rst_full", full_w, 0);     chk("rst_lvl", lvl_w, 0);
        chk("rst_wrap", wrap_w, 0);     chk("rst_err", err_w, 0);

        // 1: load, increment, cancel, clear priority
        step(1, 0, 0, 0, 0, 0, 12'h123);
        step(0, 0, 1, 0, 0, 0, 12'h000);
        step(0, 0, 1, 0, 0, 0, 12'h000);
        chk("t1_inc2", q_w, 12'h125);
        step(0, 0, 1, 1, 0, 0, 12'h000);
        chk("t1_cancel", q_w, 12'h125);
        chk("t1_cancel_wrap", wrap_w, 0);
        step(1, 1, 0, 0, 0, 0, 12'h777);
        chk("t1_clr_ld", q_w, 12'h000);

        // Async reset mid-operation, between edges
        step(1, 0, 0, 0, 1, 0, 12'h456);
        inc = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_q", q_w, 12'h000);
        chk("arst_empty", empty_w, 1);
        chk("arst_lvl", lvl_w, 0);
        inc = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // 2: wrap and saturate at both ends
        step(1, 0, 0, 0, 0, 0, 12'hFFF);
        step(0, 0, 1, 0, 0, 0, 12'h000);
        chk("t2_inc_wrap_q", q_w, 12'h000);
        chk("t2_inc_sat_q", q_s, 12'hFFF);
        chk("t2_inc_wrap_pulse", wrap_w, 1);
        chk("t2_inc_sat_pulse", wrap_s, 1);
        idle();
        chk("t2_pulse_end", wrap_w, 0);
        step(0, 1, 0, 0, 0, 0, 12'h000);
        step(0, 0, 0, 1, 0, 0, 12'h000);
        chk("t2_dec_wrap_q", q_w, 12'hFFF);
        chk("t2_dec_sat_q", q_s, 12'h000);
        chk("t2_dec_sat_pulse", wrap_s, 1);
        step(1, 0, 1, 0, 0, 0, 12'h010);
        chk("t2_ld_over_inc_wrap", wrap_w, 0);

        // 3: call / return
        step(1, 0, 1, 0, 1, 0, 12'h200);
        chk("t3_call_q", q_w, 12'h200);
        chk("t3_call_lvl", lvl_w, 1);
        step(0, 0, 1, 0, 0, 0, 12'h000);
        chk("t3_inc", q_w, 12'h201);
        step(0, 0, 0, 0, 0, 1, 12'h000);
        chk("t3_ret_q", q_w, 12'h010);
        chk("t3_ret_empty", empty_w, 1);
        chk("t3_ret_err", err_w, 0);

        // 4: overflow, then LIFO drain
        step(1, 0, 0, 0, 0, 0, 12'h100);
        for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 1, 0, 12'h000);
        chk("t4_full", full_w, 1);
        chk("t4_lvl", lvl_w, 4);
        step(0, 0, 1, 0, 1, 0, 12'h000);
        chk("t4_ovf_err", err_w, 1);
        chk("t4_ovf_lvl", lvl_w, 4);
        chk("t4_ovf_q", q_w, 12'h105);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, 1, 12'h000);
            chk("t4_lifo", q_w, 12'h103 - 12'(k));
        end

        // 5: underflow
        step(0, 0, 1, 0, 0, 1, 12'h000);
        chk("t5_udf_err", err_w, 1);
        chk("t5_udf_q", q_w, 12'h100);
        chk("t5_udf_lvl", lvl_w, 0);
        step(1, 0, 0, 0, 0, 1, 12'h0AB);
        chk("t5_udf_ld_err", err_w, 1);
        chk("t5_udf_ld_q", q_w, 12'h0AB);
        step(0, 0, 0, 0, 1, 1, 12'h000);
        chk("t5_swap_empty_err", err_w, 1);

        // 6: swap, and pop discarded by load
        step(1, 0, 0, 0, 0, 0, 12'h055);
        step(1, 0, 0, 0, 1, 0, 12'h0AA);
        step(0, 0, 0, 0, 1, 1, 12'h000);
        chk("t6_swap_q", q_w, 12'h055);
        chk("t6_swap_lvl", lvl_w, 1);
        step(0, 0, 0, 0, 1, 1, 12'h000);
        chk("t6_swap_top", q_w, 12'h0AA);
        step(0, 0, 0, 0, 1, 1, 12'h000);
        step(1, 0, 0, 0, 0, 1, 12'h300);
        chk("t6_pop_ld_q", q_w, 12'h300);
        chk("t6_pop_ld_lvl", lvl_w, 0);

        // Random mix, model-checked
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 1) ? 12'hFFE : 12'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
